// File: rtl/wbp_arbiter2.sv
// wbp_arbiter2: two-master round-robin arbiter for one Wishbone pipelined port.
// The grant is registered and held for the whole bus cycle (CYC). Request and
// response paths are combinational muxes, so they add no latency.
//
// Optional feature, selected by the macro WBARB_TIMEOUT_EN:
//   defined   - an LGTIMEOUT-bit watchdog ends a bus cycle whose slave never
//               answers. The owner gets a one-cycle err and loses the grant.
//   undefined - no watchdog. A hung slave keeps the grant, and errors come
//               only from i_merr.
//
// Handshake: a request beat transfers on a cycle with o_mstb=1 and
// i_mstall=0. Each accepted beat is answered later by exactly one
// i_mack or i_merr while o_mcyc stays high. Dropping CYC abandons any
// answers still outstanding.
//
// dbg_grant exposes the grant state (0 idle, 1 master A, 2 master B).
module wbp_arbiter2 #(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int LGTIMEOUT = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    // master A
    input  logic            i_acyc,
    input  logic            i_astb,
    input  logic            i_awe,
    input  logic [AW-1:0]   i_aaddr,
    input  logic [DW-1:0]   i_adata,
    input  logic [DW/8-1:0] i_asel,
    output logic            o_astall,
    output logic            o_aack,
    output logic            o_aerr,
    output logic [DW-1:0]   o_adata,
    // master B
    input  logic            i_bcyc,
    input  logic            i_bstb,
    input  logic            i_bwe,
    input  logic [AW-1:0]   i_baddr,
    input  logic [DW-1:0]   i_bdata,
    input  logic [DW/8-1:0] i_bsel,
    output logic            o_bstall,
    output logic            o_back,
    output logic            o_berr,
    output logic [DW-1:0]   o_bdata,
    // downstream
    output logic            o_mcyc,
    output logic            o_mstb,
    output logic            o_mwe,
    output logic [AW-1:0]   o_maddr,
    output logic [DW-1:0]   o_mdata,
    output logic [DW/8-1:0] o_msel,
    input  logic            i_mstall,
    input  logic            i_mack,
    input  logic            i_merr,
    input  logic [DW-1:0]   i_mdata,
    // grant state, for observation only
    output logic [1:0]      dbg_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GA   = 2'd1,
        GB   = 2'd2
    } grant_t;

    // r_last: 0 = A owned the bus most recently, 1 = B did.
    grant_t r_grant;
    logic   r_last;
    // r_fresh is high on the first cycle of a new grant. No legitimate answer
    // can arrive then, since the new owner's first strobe is only now on the
    // bus; anything seen is a late answer left over from an aborted cycle.
    logic   r_fresh;

    logic   timeout;
    logic   lock_a;
    logic   lock_b;
    logic   req_a;
    logic   req_b;
    logic   a_own;
    logic   b_own;
    logic   own_cyc;
    logic   own_stb;
    logic   resp_ok;

    // A master locked out by a timeout is ignored until it drops CYC.
    assign req_a = i_acyc && !lock_a;
    assign req_b = i_bcyc && !lock_b;

    // Round-robin choice among the current requests.
    function automatic grant_t pick(input logic ra, input logic rb, input logic last);
        grant_t g;
        if (ra && !rb)
            g = GA;
        else if (rb && !ra)
            g = GB;
        else if (ra && rb)
            g = last ? GA : GB;
        else
            g = IDLE;
        return g;
    endfunction

    // Grant FSM: arbitrate from IDLE, hold while the owner keeps CYC, and
    // hand straight over to the other master when the owner lets go.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_grant <= IDLE;
            r_last  <= 1'b1;
            r_fresh <= 1'b0;
        end else begin
            r_fresh <= 1'b0;
            case (r_grant)
                IDLE: begin
                    r_grant <= pick(req_a, req_b, r_last);
                    r_fresh <= (pick(req_a, req_b, r_last) != IDLE);
                end
                GA: begin
                    if (timeout) begin
                        r_grant <= IDLE;
                        r_last  <= 1'b0;
                    end else if (!i_acyc) begin
                        r_last  <= 1'b0;
                        r_grant <= req_b ? GB : IDLE;
                        r_fresh <= req_b;
                    end
                end
                GB: begin
                    if (timeout) begin
                        r_grant <= IDLE;
                        r_last  <= 1'b1;
                    end else if (!i_bcyc) begin
                        r_last  <= 1'b1;
                        r_grant <= req_a ? GA : IDLE;
                        r_fresh <= req_a;
                    end
                end
                default: begin
                    r_grant <= IDLE;
                end
            endcase
        end
    end

    assign dbg_grant = r_grant;
    assign a_own     = (r_grant == GA);
    assign b_own     = (r_grant == GB);

`ifdef WBARB_TIMEOUT_EN
    logic [LGTIMEOUT-1:0] r_count;

    // Watchdog fires when the counter has saturated while someone owns the bus.
    assign timeout = (r_grant != IDLE) && (&r_count);

    // Count bus-cycle clocks without an answer; saturate at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_reset || !o_mcyc || i_mack || i_merr)
            r_count <= '0;
        else if (!(&r_count))
            r_count <= r_count + 1'b1;
    end

    // Lock out a timed-out owner until it drops CYC.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lock_a <= 1'b0;
            lock_b <= 1'b0;
        end else begin
            lock_a <= (timeout && a_own) ? i_acyc : (lock_a && i_acyc);
            lock_b <= (timeout && b_own) ? i_bcyc : (lock_b && i_bcyc);
        end
    end
`else
    // Without the watchdog LGTIMEOUT has nothing to size; this is constant 0.
    assign timeout = (LGTIMEOUT < 0);
    assign lock_a  = 1'b0;
    assign lock_b  = 1'b0;
`endif

    // Downstream request mux: everything comes from the owner, zeros in IDLE.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        o_mwe   = 1'b0;
        o_maddr = '0;
        o_mdata = '0;
        o_msel  = '0;
        case (r_grant)
            GA: begin
                own_cyc = i_acyc;
                own_stb = i_astb;
                o_mwe   = i_awe;
                o_maddr = i_aaddr;
                o_mdata = i_adata;
                o_msel  = i_asel;
            end
            GB: begin
                own_cyc = i_bcyc;
                own_stb = i_bstb;
                o_mwe   = i_bwe;
                o_maddr = i_baddr;
                o_mdata = i_bdata;
                o_msel  = i_bsel;
            end
            default: begin
                own_cyc = 1'b0;
            end
        endcase
    end

    // The watchdog pulls CYC low on its firing cycle; the grant is IDLE after.
    assign o_mcyc  = own_cyc && !timeout;
    assign o_mstb  = own_stb && o_mcyc;

    // Answers are passed on only inside a live, already-established cycle.
    assign resp_ok = o_mcyc && !r_fresh;

    // Response routing: the owner sees the slave, the other master waits.
    assign o_astall = a_own ? i_mstall : 1'b1;
    assign o_bstall = b_own ? i_mstall : 1'b1;
    assign o_aack   = a_own && i_mack && resp_ok;
    assign o_back   = b_own && i_mack && resp_ok;
    assign o_aerr   = a_own && ((i_merr && resp_ok) || timeout);
    assign o_berr   = b_own && ((i_merr && resp_ok) || timeout);
    assign o_adata  = i_mdata;
    assign o_bdata  = i_mdata;

endmodule

// File: tb/tb_wbp_arbiter2.sv
// tb_wbp_arbiter2: directed bench for wbp_arbiter2. Responses expected at the
// masters are queued as {port, err, data}; a negedge monitor pops and compares
// every ack/err the arbiter presents. Grant, stall and downstream mux values
// are checked directly against hand-computed constants. The timeout scenario
// is included when WBARB_TIMEOUT_EN is defined (LGTIMEOUT = 4).
module tb_wbp_arbiter2;

    localparam int AW = 12;
    localparam int DW = 32;
`ifdef WBARB_TIMEOUT_EN
    localparam int LGT = 4;
`else
    localparam int LGT = 8;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            i_acyc, i_astb, i_awe;
    logic [AW-1:0]   i_aaddr;
    logic [DW-1:0]   i_adata;
    logic [DW/8-1:0] i_asel;
    logic            o_astall, o_aack, o_aerr;
    logic [DW-1:0]   o_adata;
    logic            i_bcyc, i_bstb, i_bwe;
    logic [AW-1:0]   i_baddr;
    logic [DW-1:0]   i_bdata;
    logic [DW/8-1:0] i_bsel;
    logic            o_bstall, o_back, o_berr;
    logic [DW-1:0]   o_bdata;
    logic            o_mcyc, o_mstb, o_mwe;
    logic [AW-1:0]   o_maddr;
    logic [DW-1:0]   o_mdata;
    logic [DW/8-1:0] o_msel;
    logic            i_mstall, i_mack, i_merr;
    logic [DW-1:0]   i_mdata;
    logic [1:0]      dbg_grant;

    logic [DW+1:0]   exp_q[$];
    logic [DW+1:0]   mon_act;
    logic [DW+1:0]   mon_exp;
    int              n_cmp  = 0;
    int              n_fail = 0;

    wbp_arbiter2 #(.AW(AW), .DW(DW), .LGTIMEOUT(LGT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_acyc(i_acyc), .i_astb(i_astb), .i_awe(i_awe), .i_aaddr(i_aaddr),
        .i_adata(i_adata), .i_asel(i_asel),
        .o_astall(o_astall), .o_aack(o_aack), .o_aerr(o_aerr), .o_adata(o_adata),
        .i_bcyc(i_bcyc), .i_bstb(i_bstb), .i_bwe(i_bwe), .i_baddr(i_baddr),
        .i_bdata(i_bdata), .i_bsel(i_bsel),
        .o_bstall(o_bstall), .o_back(o_back), .o_berr(o_berr), .o_bdata(o_bdata),
        .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe), .o_maddr(o_maddr),
        .o_mdata(o_mdata), .o_msel(o_msel),
        .i_mstall(i_mstall), .i_mack(i_mack), .i_merr(i_merr), .i_mdata(i_mdata),
        .dbg_grant(dbg_grant)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs follow the inputs just driven.
    task automatic settle();
        #1;
    endtask

    task automatic exp_resp(input logic port_b, input logic err, input logic [DW-1:0] d);
        exp_q.push_back({port_b, err, d});
    endtask

    task automatic clear_inputs();
        i_acyc = 0; i_astb = 0; i_awe = 0; i_aaddr = '0; i_adata = '0; i_asel = '0;
        i_bcyc = 0; i_bstb = 0; i_bwe = 0; i_baddr = '0; i_bdata = '0; i_bsel = '0;
        i_mstall = 0; i_mack = 0; i_merr = 0; i_mdata = '0;
    endtask

    // Response monitor: every ack/err presented to a master is scored.
    always @(negedge clk) begin
        if (!rst) begin
            if ((o_aack || o_aerr) && (o_back || o_berr)) begin
                n_cmp++;
                n_fail++;
                $display("FAIL both_ports: a=%b/%b b=%b/%b, expected one port at most",
                         o_aack, o_aerr, o_back, o_berr);
            end else if (o_aack || o_aerr || o_back || o_berr) begin
                mon_act = (o_back || o_berr) ? {1'b1, o_berr, o_bdata} : {1'b0, o_aerr, o_adata};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_resp: got 0x%0h, expected none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        n_fail++;
                        $display("FAIL resp: got 0x%0h, expected 0x%0h", mon_act, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        clear_inputs();
        rst = 1;
        step();
        step();
        settle();
        check("rst_grant", dbg_grant, 0);
        check("rst_mcyc", o_mcyc, 0);
        check("rst_astall", o_astall, 1);
        check("rst_bstall", o_bstall, 1);
        rst = 0;

        // 1: single write from A, ack two cycles after acceptance
        step();
        i_acyc = 1; i_astb = 1; i_awe = 1; i_aaddr = 12'h010; i_adata = 32'hDEADBEEF; i_asel = 4'hF;
        settle();
        check("t1_mcyc_first", o_mcyc, 0);
        check("t1_astall_idle", o_astall, 1);
        step(); settle();
        check("t1_mcyc", o_mcyc, 1);
        check("t1_mstb", o_mstb, 1);
        check("t1_mwe", o_mwe, 1);
        check("t1_maddr", o_maddr, 12'h010);
        check("t1_mdata", o_mdata, 32'hDEADBEEF);
        check("t1_msel", o_msel, 4'hF);
        check("t1_astall", o_astall, 0);
        check("t1_bstall_a", o_bstall, 1);
        step(); i_astb = 0; settle();
        check("t1_mstb_low", o_mstb, 0);
        check("t1_bstall_b", o_bstall, 1);
        step(); i_mack = 1; exp_resp(1'b0, 1'b0, 32'h0); settle();
        check("t1_bstall_c", o_bstall, 1);
        step(); i_mack = 0; i_acyc = 0; i_awe = 0; settle();
        check("t1_mcyc_drop", o_mcyc, 0);
        step(); settle();
        check("t1_idle", dbg_grant, 0);

        // 2: simultaneous requests from reset, then alternation
        step(); rst = 1;
        step(); rst = 0;
        step(); i_acyc = 1; i_bcyc = 1; settle();
        check("t2_idle", dbg_grant, 0);
        step(); settle();
        check("t2_a_first", dbg_grant, 1);
        check("t2_bstall", o_bstall, 1);
        step(); i_acyc = 0; settle();
        check("t2_a_hold", dbg_grant, 1);
        check("t2_mcyc_drop", o_mcyc, 0);
        step(); settle();
        check("t2_b_next", dbg_grant, 2);
        check("t2_b_mcyc", o_mcyc, 1);
        check("t2_astall", o_astall, 1);
        step(); i_bcyc = 0; settle();
        check("t2_b_drop", o_mcyc, 0);
        step(); settle();
        check("t2_back_idle", dbg_grant, 0);
        step(); i_acyc = 1; i_bcyc = 1;
        step(); settle();
        check("t2_repeat_a", dbg_grant, 1);
        step(); i_acyc = 0; i_bcyc = 0;
        step(); settle();
        check("t2_end_idle", dbg_grant, 0);

        // 3: B burst of 3 reads under stall while A waits
        step();
        i_bcyc = 1; i_bstb = 1; i_bwe = 0; i_baddr = 12'h100;
        i_acyc = 1; i_astb = 1; i_aaddr = 12'h0AA; i_mstall = 1;
        settle();
        check("t3_idle", dbg_grant, 0);
        step(); settle();
        check("t3_b_granted", dbg_grant, 2);
        check("t3_bstall1", o_bstall, 1);
        check("t3_astall1", o_astall, 1);
        check("t3_maddr0", o_maddr, 12'h100);
        step(); settle();
        check("t3_bstall2", o_bstall, 1);
        check("t3_astall2", o_astall, 1);
        step(); i_mstall = 0; settle();
        check("t3_bstall_free", o_bstall, 0);
        check("t3_astall3", o_astall, 1);
        step(); i_baddr = 12'h101; i_mack = 1; i_mdata = 32'h11111111;
        exp_resp(1'b1, 1'b0, 32'h11111111); settle();
        check("t3_maddr1", o_maddr, 12'h101);
        check("t3_astall4", o_astall, 1);
        step(); i_baddr = 12'h102; i_mdata = 32'h22222222;
        exp_resp(1'b1, 1'b0, 32'h22222222); settle();
        check("t3_astall5", o_astall, 1);
        step(); i_bstb = 0; i_mdata = 32'h33333333;
        exp_resp(1'b1, 1'b0, 32'h33333333); settle();
        check("t3_mstb_low", o_mstb, 0);
        step(); i_mack = 0; i_bcyc = 0; i_mdata = '0; settle();
        check("t3_b_drop", o_mcyc, 0);
        step(); i_aaddr = 12'h020; settle();
        check("t3_a_next", dbg_grant, 1);
        check("t3_a_maddr", o_maddr, 12'h020);

        // 4: A aborts with a read outstanding, late acks must vanish
        step(); i_astb = 0; i_bcyc = 1; i_bstb = 0; settle();
        check("t4_bstall", o_bstall, 1);
        step(); i_acyc = 0; i_mack = 1; settle();
        check("t4_mcyc_abort", o_mcyc, 0);
        check("t4_aack_drop", o_aack, 0);
        step(); settle();
        check("t4_b_granted", dbg_grant, 2);
        check("t4_back_late", o_back, 0);
        check("t4_aack_late", o_aack, 0);
        step(); i_mack = 0; i_bstb = 1; i_baddr = 12'h200; settle();
        check("t4_mstb", o_mstb, 1);
        check("t4_maddr", o_maddr, 12'h200);

        // 5: reset in the middle of a B burst
        step(); i_bstb = 0; i_mack = 1; i_mdata = 32'h55555555;
        exp_resp(1'b1, 1'b0, 32'h55555555);
        step(); i_mack = 0; rst = 1; i_acyc = 1;
        step(); rst = 0; i_mack = 1; settle();
        check("t5_idle", dbg_grant, 0);
        check("t5_mcyc", o_mcyc, 0);
        check("t5_back", o_back, 0);
        step(); i_mack = 0; i_mdata = '0; settle();
        check("t5_a_favored", dbg_grant, 1);
        step(); i_acyc = 0; i_bcyc = 0;
        step(); step(); settle();
        check("t5_end_idle", dbg_grant, 0);

`ifdef WBARB_TIMEOUT_EN
        // 6: slave never answers A; watchdog fires after 15 cycles
        step(); i_acyc = 1; i_astb = 1; i_awe = 0; i_aaddr = 12'h030; i_mstall = 1;
        for (int k = 0; k < 15; k++) begin
            step();
            if (k == 2) i_bcyc = 1;
            settle();
            check("t6_no_err", o_aerr, 0);
            check("t6_mcyc", o_mcyc, 1);
        end
        step(); exp_resp(1'b0, 1'b1, 32'h0); settle();
        check("t6_aerr", o_aerr, 1);
        check("t6_mcyc_forced", o_mcyc, 0);
        step(); i_acyc = 0; i_astb = 0; settle();
        check("t6_mcyc_second", o_mcyc, 0);
        check("t6_idle", dbg_grant, 0);
        step(); settle();
        check("t6_b_granted", dbg_grant, 2);
        i_mstall = 0; i_bcyc = 0;
`endif

        step(); step(); settle();
        check("queue_drained", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
